// File: rtl/gsu_pkg.sv
// gsu_pkg: shared types and constants for the GSU instruction cache.
//   gsu_state_e    - fetch FSM state encoding
//   DefCacheBytes  - default total cache size in bytes
//   DefLineBytes   - default line size in bytes
//   CbrAlignMask   - cbr alignment mask for the default line size
//   cbr_align_mask - the same mask for an arbitrary line size
package gsu_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StFill,
    StBypass,
    StResp
  } gsu_state_e;

  localparam int unsigned DefCacheBytes = 512;
  localparam int unsigned DefLineBytes  = 16;

  // Clears the in-line offset bits so cbr always sits on a line boundary.
  function automatic logic [15:0] cbr_align_mask(input int unsigned line_bytes);
    return ~16'(line_bytes - 1);
  endfunction

  localparam logic [15:0] CbrAlignMask = cbr_align_mask(DefLineBytes);

endpackage

// File: rtl/gsu_cache_ram.sv
// gsu_cache_ram: byte storage for the instruction cache.
//   clkin                     - clock, rising edge
//   reset                     - synchronous active-high, clears the read registers only
//   we / waddr / wdata        - single write port
//   fetch_addr / fetch_rdata  - synchronous read port used by the fetch FSM
//   snes_addr / snes_rdata    - synchronous read port for the SNES side
module gsu_cache_ram #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = 9
) (
  input  logic          clkin,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] fetch_addr,
  output logic [7:0]    fetch_rdata,
  input  logic [AW-1:0] snes_addr,
  output logic [7:0]    snes_rdata
);

  logic [7:0] mem [DEPTH];

  // Contents survive reset; only the read registers are cleared.
  always_ff @(posedge clkin) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      fetch_rdata <= 8'h00;
      snes_rdata  <= 8'h00;
    end else begin
      fetch_rdata <= mem[fetch_addr];
      snes_rdata  <= mem[snes_addr];
    end
  end

endmodule

// File: rtl/gsu_icache.sv
// gsu_icache: direct-mapped instruction cache window for the GSU.
//   clkin, reset                     - clock and synchronous active-high reset
//   snes_we/addr/di, snes_do         - SNES-side byte access to the cache RAM
//   cbr_wr, cbr_in, cbr_out          - cache base register load / readback
//   flush                            - invalidate all lines
//   fetch_req/pbr/pc, fetch_ack/data - GSU instruction fetch handshake
//   rom_req/addr, rom_ack/data       - ROM read handshake used for fills and bypass
//   busy                             - FSM is away from idle
module gsu_icache
  import gsu_pkg::*;
#(
  parameter int unsigned CACHE_BYTES = DefCacheBytes,
  parameter int unsigned LINE_BYTES  = DefLineBytes
) (
  input  logic                           clkin,
  input  logic                           reset,
  input  logic                           snes_we,
  input  logic [$clog2(CACHE_BYTES)-1:0] snes_addr,
  input  logic [7:0]                     snes_di,
  output logic [7:0]                     snes_do,
  input  logic                           cbr_wr,
  input  logic [15:0]                    cbr_in,
  output logic [15:0]                    cbr_out,
  input  logic                           flush,
  input  logic                           fetch_req,
  input  logic [7:0]                     fetch_pbr,
  input  logic [15:0]                    fetch_pc,
  output logic                           fetch_ack,
  output logic [7:0]                     fetch_data,
  output logic                           rom_req,
  output logic [23:0]                    rom_addr,
  input  logic                           rom_ack,
  input  logic [7:0]                     rom_data,
  output logic                           busy
);

  localparam int unsigned IdxW   = $clog2(CACHE_BYTES);
  localparam int unsigned OffW   = $clog2(LINE_BYTES);
  localparam int unsigned NLines = CACHE_BYTES / LINE_BYTES;
  localparam int unsigned LineW  = IdxW - OffW;
  localparam logic [15:0] CbrMask = cbr_align_mask(LINE_BYTES);

  gsu_state_e        state_q;
  logic [7:0]        pbr_q;
  logic [15:0]       pc_q;
  logic [IdxW-1:0]   idx_q;
  logic              bypass_q;
  logic [OffW-1:0]   cnt_q;
  logic [NLines-1:0] valid_q;
  logic [15:0]       cbr_q;
  logic              flush_pend_q;
  logic              cbr_pend_q;
  logic [15:0]       cbr_pend_val_q;
  logic              rom_req_q;
  logic [23:0]       rom_addr_q;
  logic [7:0]        byp_data_q;
  logic              fetch_ack_q;
  logic [7:0]        fetch_data_q;

  logic [15:0]       fetch_off;
  logic              fetch_cacheable;
  logic [LineW-1:0]  line_idx;
  logic [LineW-1:0]  snes_line;
  logic [OffW-1:0]   cnt_inc;
  logic              rom_beat;
  logic              ram_we;
  logic [IdxW-1:0]   ram_waddr;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_fetch_rdata;

  assign fetch_off       = fetch_pc - cbr_q;
  assign fetch_cacheable = (fetch_off[15:IdxW] == '0);
  assign line_idx        = idx_q[IdxW-1:OffW];
  assign snes_line       = snes_addr[IdxW-1:OffW];
  assign cnt_inc         = cnt_q + 1'b1;
  // rom_ack only counts while a request is actually outstanding.
  assign rom_beat        = rom_req_q & rom_ack;

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = snes_addr;
    ram_wdata = snes_di;
    if (state_q == StIdle && snes_we) begin
      ram_we = 1'b1;
    end else if (state_q == StFill && rom_beat) begin
      ram_we    = 1'b1;
      ram_waddr = {line_idx, cnt_q};
      ram_wdata = rom_data;
    end
  end

  gsu_cache_ram #(
    .DEPTH(CACHE_BYTES),
    .AW   (IdxW)
  ) u_ram (
    .clkin      (clkin),
    .reset      (reset),
    .we         (ram_we),
    .waddr      (ram_waddr),
    .wdata      (ram_wdata),
    .fetch_addr (idx_q),
    .fetch_rdata(ram_fetch_rdata),
    .snes_addr  (snes_addr),
    .snes_rdata (snes_do)
  );

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q        <= StIdle;
      pbr_q          <= 8'h00;
      pc_q           <= 16'h0000;
      idx_q          <= '0;
      bypass_q       <= 1'b0;
      cnt_q          <= '0;
      valid_q        <= '0;
      cbr_q          <= 16'h0000;
      flush_pend_q   <= 1'b0;
      cbr_pend_q     <= 1'b0;
      cbr_pend_val_q <= 16'h0000;
      rom_req_q      <= 1'b0;
      rom_addr_q     <= 24'h000000;
      byp_data_q     <= 8'h00;
      fetch_ack_q    <= 1'b0;
      fetch_data_q   <= 8'h00;
    end else begin
      fetch_ack_q <= 1'b0;

      // Maintenance requests arriving mid-fetch are parked until RESP.
      if (state_q != StIdle) begin
        if (flush) begin
          flush_pend_q <= 1'b1;
        end
        if (cbr_wr) begin
          cbr_pend_q     <= 1'b1;
          cbr_pend_val_q <= cbr_in & CbrMask;
        end
      end

      case (state_q)
        StIdle: begin
          if (snes_we && (&snes_addr[OffW-1:0])) begin
            valid_q[snes_line] <= 1'b1;
          end
          if (cbr_wr || flush) begin
            valid_q <= '0;
          end
          if (cbr_wr) begin
            cbr_q <= cbr_in & CbrMask;
          end
          if (fetch_req) begin
            pbr_q    <= fetch_pbr;
            pc_q     <= fetch_pc;
            idx_q    <= fetch_off[IdxW-1:0];
            bypass_q <= ~fetch_cacheable;
            if (fetch_cacheable) begin
              state_q <= StLookup;
            end else begin
              state_q    <= StBypass;
              rom_req_q  <= 1'b1;
              rom_addr_q <= {fetch_pbr, fetch_pc};
            end
          end
        end

        StLookup: begin
          if (valid_q[line_idx]) begin
            state_q <= StResp;
          end else begin
            // cbr is line aligned, so cbr + line*LINE_BYTES is just pc with the
            // in-line offset cleared; this keeps fills independent of a cbr update.
            state_q    <= StFill;
            cnt_q      <= '0;
            rom_req_q  <= 1'b1;
            rom_addr_q <= {pbr_q, pc_q[15:OffW], {OffW{1'b0}}};
          end
        end

        StFill: begin
          if (rom_beat) begin
            cnt_q <= cnt_inc;
            if (&cnt_q) begin
              valid_q[line_idx] <= 1'b1;
              rom_req_q         <= 1'b0;
              state_q           <= StLookup;
            end else begin
              rom_addr_q <= {pbr_q, pc_q[15:OffW], cnt_inc};
            end
          end
        end

        StBypass: begin
          if (rom_beat) begin
            byp_data_q <= rom_data;
            rom_req_q  <= 1'b0;
            state_q    <= StResp;
          end
        end

        StResp: begin
          fetch_ack_q  <= 1'b1;
          fetch_data_q <= bypass_q ? byp_data_q : ram_fetch_rdata;
          state_q      <= StIdle;
          if (flush_pend_q || cbr_pend_q || flush || cbr_wr) begin
            valid_q <= '0;
          end
          if (cbr_wr) begin
            cbr_q <= cbr_in & CbrMask;
          end else if (cbr_pend_q) begin
            cbr_q <= cbr_pend_val_q;
          end
          flush_pend_q <= 1'b0;
          cbr_pend_q   <= 1'b0;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign fetch_ack  = fetch_ack_q;
  assign fetch_data = fetch_data_q;
  assign rom_req    = rom_req_q;
  assign rom_addr   = rom_addr_q;
  assign cbr_out    = cbr_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_gsu_icache.sv
// tb_gsu_icache: directed bench for gsu_icache with a ROM responder model and
// scoreboards for expected ROM addresses and expected fetch data.
module tb_gsu_icache;

  logic        clkin = 1'b0;
  logic        reset;
  logic        snes_we;
  logic [8:0]  snes_addr;
  logic [7:0]  snes_di;
  logic [7:0]  snes_do;
  logic        cbr_wr;
  logic [15:0] cbr_in;
  logic [15:0] cbr_out;
  logic        flush;
  logic        fetch_req;
  logic [7:0]  fetch_pbr;
  logic [15:0] fetch_pc;
  logic        fetch_ack;
  logic [7:0]  fetch_data;
  logic        rom_req;
  logic [23:0] rom_addr;
  logic        rom_ack;
  logic [7:0]  rom_data;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  int rom_wait = 0;
  int rom_req_cycles = 0;

  logic [23:0] rom_q[$];
  logic [7:0]  data_q[$];

  always #5 clkin = ~clkin;

  gsu_icache #(
    .CACHE_BYTES(512),
    .LINE_BYTES (16)
  ) dut (
    .clkin     (clkin),
    .reset     (reset),
    .snes_we   (snes_we),
    .snes_addr (snes_addr),
    .snes_di   (snes_di),
    .snes_do   (snes_do),
    .cbr_wr    (cbr_wr),
    .cbr_in    (cbr_in),
    .cbr_out   (cbr_out),
    .flush     (flush),
    .fetch_req (fetch_req),
    .fetch_pbr (fetch_pbr),
    .fetch_pc  (fetch_pc),
    .fetch_ack (fetch_ack),
    .fetch_data(fetch_data),
    .rom_req   (rom_req),
    .rom_addr  (rom_addr),
    .rom_ack   (rom_ack),
    .rom_data  (rom_data),
    .busy      (busy)
  );

  function automatic logic [7:0] rom_byte(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // ROM responder: acks after rom_wait idle cycles, checks each accepted address.
  initial begin
    int wcnt;
    logic [23:0] exp_a;
    wcnt = 0;
    rom_ack = 1'b0;
    rom_data = 8'h00;
    forever begin
      @(negedge clkin);
      if (rom_req) begin
        rom_req_cycles++;
        if (wcnt >= rom_wait) begin
          rom_ack  = 1'b1;
          rom_data = rom_byte(rom_addr);
          wcnt     = 0;
          if (rom_q.size() == 0) begin
            check("rom_unexpected", {8'h00, rom_addr}, 32'hFFFFFFFF);
          end else begin
            exp_a = rom_q.pop_front();
            check("rom_addr", {8'h00, rom_addr}, {8'h00, exp_a});
          end
        end else begin
          rom_ack = 1'b0;
          wcnt++;
        end
      end else begin
        rom_ack = 1'b0;
        wcnt    = 0;
      end
    end
  end

  // Fetch monitor: every ack pops the expected byte.
  initial begin
    logic [7:0] exp_d;
    forever begin
      @(negedge clkin);
      if (fetch_ack) begin
        if (data_q.size() == 0) begin
          check("fetch_unexpected", {24'h0, fetch_data}, 32'hFFFFFFFF);
        end else begin
          exp_d = data_q.pop_front();
          check("fetch_data", {24'h0, fetch_data}, {24'h0, exp_d});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_fetch(input logic [7:0] pbr, input logic [15:0] pc);
    @(negedge clkin);
    fetch_req = 1'b1;
    fetch_pbr = pbr;
    fetch_pc  = pc;
    @(posedge clkin);
    #1 fetch_req = 1'b0;
  endtask

  task automatic wait_ack(output int lat);
    lat = 0;
    while (lat < 300) begin
      @(negedge clkin);
      lat++;
      if (fetch_ack) break;
    end
    if (!fetch_ack) check("fetch_timeout", 32'd0, 32'd1);
  endtask

  task automatic push_line(input logic [23:0] base);
    for (int i = 0; i < 16; i++) rom_q.push_back(base + 24'(i));
  endtask

  task automatic snes_write(input logic [8:0] a, input logic [7:0] d);
    @(negedge clkin);
    snes_we   = 1'b1;
    snes_addr = a;
    snes_di   = d;
    @(posedge clkin);
    #1 snes_we = 1'b0;
  endtask

  task automatic snes_read(input string tag, input logic [8:0] a, input logic [7:0] exp);
    @(negedge clkin);
    snes_addr = a;
    @(negedge clkin);
    check(tag, {24'h0, snes_do}, {24'h0, exp});
  endtask

  task automatic pulse_cbr(input logic [15:0] v);
    cbr_wr = 1'b1;
    cbr_in = v;
    @(posedge clkin);
    #1 cbr_wr = 1'b0;
  endtask

  initial begin
    int lat;
    int rc;
    reset = 1'b1;
    snes_we = 1'b0;
    snes_addr = '0;
    snes_di = 8'h00;
    cbr_wr = 1'b0;
    cbr_in = 16'h0000;
    flush = 1'b0;
    fetch_req = 1'b0;
    fetch_pbr = 8'h00;
    fetch_pc = 16'h0000;

    repeat (3) @(posedge clkin);
    @(negedge clkin);
    check("rst_fetch_ack", {31'h0, fetch_ack}, 32'd0);
    check("rst_fetch_data", {24'h0, fetch_data}, 32'd0);
    check("rst_rom_req", {31'h0, rom_req}, 32'd0);
    check("rst_rom_addr", {8'h0, rom_addr}, 32'd0);
    check("rst_snes_do", {24'h0, snes_do}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_cbr_out", {16'h0, cbr_out}, 32'd0);
    reset = 1'b0;

    // Cold miss: fill line 0 in order, return byte 5.
    push_line(24'h010000);
    data_q.push_back(rom_byte(24'h010005));
    start_fetch(8'h01, 16'h0005);
    check("miss_busy", {31'h0, busy}, 32'd1);
    wait_ack(lat);
    check("miss_rom_drained", rom_q.size(), 32'd0);
    snes_read("snes_do_fill", 9'h00F, rom_byte(24'h01000F));

    // Hit: 3-cycle latency, no ROM traffic.
    rc = rom_req_cycles;
    data_q.push_back(rom_byte(24'h010007));
    start_fetch(8'h01, 16'h0007);
    wait_ack(lat);
    check("hit_latency", lat, 32'd3);
    check("hit_no_rom", rom_req_cycles, rc);

    // SNES fill of line 1 marks it valid on the last byte.
    for (int i = 16; i < 32; i++) snes_write(9'(i), 8'hAA);
    rc = rom_req_cycles;
    data_q.push_back(8'hAA);
    start_fetch(8'h01, 16'h001F);
    wait_ack(lat);
    check("snes_line_latency", lat, 32'd3);
    check("snes_line_no_rom", rom_req_cycles, rc);

    // Write and fetch in the same idle cycle: lookup sees the new byte.
    data_q.push_back(8'h3C);
    @(negedge clkin);
    snes_we = 1'b1;
    snes_addr = 9'h007;
    snes_di = 8'h3C;
    fetch_req = 1'b1;
    fetch_pbr = 8'h01;
    fetch_pc = 16'h0007;
    @(posedge clkin);
    #1 begin
      snes_we = 1'b0;
      fetch_req = 1'b0;
    end
    wait_ack(lat);
    check("wr_fetch_latency", lat, 32'd3);

    // Bypass outside the window; a SNES write while busy is dropped.
    snes_write(9'h030, 8'h11);
    rom_wait = 3;
    rom_q.push_back(24'h020200);
    data_q.push_back(rom_byte(24'h020200));
    start_fetch(8'h02, 16'h0200);
    snes_write(9'h030, 8'h99);
    wait_ack(lat);
    rom_wait = 0;
    check("bypass_rom_drained", rom_q.size(), 32'd0);
    snes_read("busy_write_dropped", 9'h030, 8'h11);
    snes_read("bypass_ram_intact", 9'h000, rom_byte(24'h010000));
    rc = rom_req_cycles;
    data_q.push_back(rom_byte(24'h010000));
    start_fetch(8'h01, 16'h0000);
    wait_ack(lat);
    check("post_bypass_hit", rom_req_cycles, rc);

    // cbr load aligns and invalidates; fill from the new base with ROM waits.
    @(negedge clkin);
    pulse_cbr(16'h8013);
    check("cbr_aligned", {16'h0, cbr_out}, 32'h8010);
    rom_wait = 1;
    push_line(24'h038010);
    data_q.push_back(rom_byte(24'h038010));
    start_fetch(8'h03, 16'h8010);
    wait_ack(lat);
    rom_wait = 0;
    check("cbr_rom_drained", rom_q.size(), 32'd0);

    // Flush during a fill: fetch completes, then the line is gone.
    push_line(24'h038020);
    data_q.push_back(rom_byte(24'h038025));
    start_fetch(8'h03, 16'h8025);
    repeat (4) @(posedge clkin);
    #1 flush = 1'b1;
    @(posedge clkin);
    #1 flush = 1'b0;
    wait_ack(lat);
    check("flush_rom_drained", rom_q.size(), 32'd0);

    // Same pc misses again; a cbr load during this fill is deferred.
    push_line(24'h038020);
    data_q.push_back(rom_byte(24'h038025));
    start_fetch(8'h03, 16'h8025);
    repeat (3) @(posedge clkin);
    #1 pulse_cbr(16'h0000);
    @(negedge clkin);
    check("cbr_deferred", {16'h0, cbr_out}, 32'h8010);
    check("cbr_deferred_busy", {31'h0, busy}, 32'd1);
    wait_ack(lat);
    check("cbr_applied", {16'h0, cbr_out}, 32'h0000);
    check("refill_rom_drained", rom_q.size(), 32'd0);

    // Deferred cbr load also invalidated everything.
    push_line(24'h010000);
    data_q.push_back(rom_byte(24'h010005));
    start_fetch(8'h01, 16'h0005);
    wait_ack(lat);
    check("final_rom_drained", rom_q.size(), 32'd0);
    repeat (2) @(negedge clkin);
    check("final_data_drained", data_q.size(), 32'd0);
    check("final_idle", {31'h0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
